// File: rtl/regfile_pkg.sv
// Shared constants and enumerations for the register-file controller.
package regfile_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e r_last_gnt;

  // Grant selection: single requester wins outright, tie goes to the other side of last_gnt
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (r_last_gnt == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the most recent winner; reset favours A on the first tie
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_last_gnt <= REQ_B;
    end else if (gnt[0]) begin
      r_last_gnt <= REQ_A;
    end else if (gnt[1]) begin
      r_last_gnt <= REQ_B;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Shares an 8x4 register file between requesters A and B, with a post-reset
// initialisation sweep, a one-cycle global flush and a registered read port.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit                SWEEP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_load,
  output logic              rf_clr,
  input  logic [DATA_W-1:0] rf_q
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep_cnt;
  logic [ADDR_W-1:0] w_sweep_cnt_nxt;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_rd_a;
  logic              w_rd_b;

  // Arbitration only happens in RUN outside a flush cycle, and never while held in reset
  assign w_arb_en = clr_n && (r_state == RUN) && !flush;

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (w_arb_en),
    .req   ({b_req, a_req}),
    .gnt   (w_gnt)
  );

  assign a_gnt  = w_gnt[0];
  assign b_gnt  = w_gnt[1];
  assign w_rd_a = w_gnt[0] & ~a_we;
  assign w_rd_b = w_gnt[1] & ~b_we;

  // State and sweep counter; reset restarts the sweep from entry 0
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= SWEEP_EN ? SWEEP : RUN;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
    end
  end

  // Next state and register-file drive; everything quiet while reset is held
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_cnt_nxt = r_sweep_cnt;
    busy            = 1'b0;
    rf_load         = 1'b0;
    rf_clr          = 1'b0;
    rf_addr         = '0;
    rf_din          = '0;
    if (clr_n) begin
      case (r_state)
        SWEEP: begin
          rf_addr         = r_sweep_cnt;
          rf_din          = INIT_VAL;
          rf_load         = 1'b1;
          busy            = 1'b1;
          w_sweep_cnt_nxt = r_sweep_cnt + ADDR_W'(1);
          if (r_sweep_cnt == LAST_IDX) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (flush) begin
            rf_clr = 1'b1;
            busy   = 1'b1;
          end else if (w_gnt[0]) begin
            rf_addr = a_addr;
            rf_din  = a_wdata;
            rf_load = a_we;
          end else if (w_gnt[1]) begin
            rf_addr = b_addr;
            rf_din  = b_wdata;
            rf_load = b_we;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // Capture read data for a granted read and flag its owner for one cycle
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rdata    <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= w_rd_a;
      b_rvalid <= w_rd_b;
      if (w_rd_a || w_rd_b) begin
        rdata <= rf_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x4 register file model.
module tb_regfile_ctrl;

  logic       clk;
  logic       clr_n;
  logic       a_req, a_we, b_req, b_we;
  logic [2:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0] rdata;
  logic       flush, busy;
  logic [3:0] rf_din;
  logic [2:0] rf_addr;
  logic       rf_load, rf_clr;
  logic [3:0] rf_q;

  logic       clr2_n;
  logic       a2_req, a2_we, b2_req, b2_we;
  logic [2:0] a2_addr, b2_addr;
  logic [3:0] a2_wdata, b2_wdata;
  logic       a2_gnt, a2_rvalid, b2_gnt, b2_rvalid;
  logic [3:0] rdata2;
  logic       flush2, busy2;
  logic [3:0] rf_din2;
  logic [2:0] rf_addr2;
  logic       rf_load2, rf_clr2;
  logic [3:0] rf_q2;

  logic [3:0] mem [8];

  int n_vec;
  int n_bad;

  regfile_ctrl #(.INIT_VAL(4'h5), .SWEEP_EN(1'b1)) u_dut (
    .clk(clk), .clr_n(clr_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .flush(flush), .busy(busy),
    .rf_din(rf_din), .rf_addr(rf_addr), .rf_load(rf_load), .rf_clr(rf_clr),
    .rf_q(rf_q)
  );

  regfile_ctrl #(.INIT_VAL(4'h0), .SWEEP_EN(1'b0)) u_dut_nosweep (
    .clk(clk), .clr_n(clr2_n),
    .a_req(a2_req), .a_we(a2_we), .a_addr(a2_addr), .a_wdata(a2_wdata),
    .a_gnt(a2_gnt), .a_rvalid(a2_rvalid),
    .b_req(b2_req), .b_we(b2_we), .b_addr(b2_addr), .b_wdata(b2_wdata),
    .b_gnt(b2_gnt), .b_rvalid(b2_rvalid),
    .rdata(rdata2), .flush(flush2), .busy(busy2),
    .rf_din(rf_din2), .rf_addr(rf_addr2), .rf_load(rf_load2), .rf_clr(rf_clr2),
    .rf_q(rf_q2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: combinational read, clear-all or single write at the edge
  assign rf_q  = mem[rf_addr];
  assign rf_q2 = 4'h0;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
    end else if (rf_load) begin
      mem[rf_addr] <= rf_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    clr_n = 1'b0; flush = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 4'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 4'h0;
    clr2_n = 1'b0; flush2 = 1'b0;
    a2_req = 1'b0; a2_we = 1'b0; a2_addr = 3'd0; a2_wdata = 4'h0;
    b2_req = 1'b0; b2_we = 1'b0; b2_addr = 3'd0; b2_wdata = 4'h0;
    #2;

    // Reset state
    chk("rst_busy",     8'(busy),     8'd0);
    chk("rst_rf_load",  8'(rf_load),  8'd0);
    chk("rst_rdata",    8'(rdata),    8'h0);
    chk("rst_a_rvalid", 8'(a_rvalid), 8'd0);
    chk("rst_b_rvalid", 8'(b_rvalid), 8'd0);
    tick();
    tick();

    // Initialisation sweep: 8 cycles, addresses 0..7, flush ignored
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      flush = (i == 2);
      #1;
      chk("sweep_addr", 8'(rf_addr), 8'(i));
      chk("sweep_din",  8'(rf_din),  8'h5);
      chk("sweep_load", 8'(rf_load), 8'd1);
      chk("sweep_busy", 8'(busy),    8'd1);
      chk("sweep_clr",  8'(rf_clr),  8'd0);
      chk("sweep_agnt", 8'(a_gnt),   8'd0);
      tick();
    end

    // A reads entry 7 right after the sweep
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd7;
    #1;
    chk("run_busy",    8'(busy),    8'd0);
    chk("rd7_a_gnt",   8'(a_gnt),   8'd1);
    chk("rd7_addr",    8'(rf_addr), 8'd7);
    chk("rd7_load",    8'(rf_load), 8'd0);
    tick();

    // A writes entry 3 = A; read result of entry 7 appears this cycle
    a_we = 1'b1; a_addr = 3'd3; a_wdata = 4'hA;
    #1;
    chk("rd7_a_rvalid", 8'(a_rvalid), 8'd1);
    chk("rd7_rdata",    8'(rdata),    8'h5);
    chk("wr3_a_gnt",    8'(a_gnt),    8'd1);
    chk("wr3_load",     8'(rf_load),  8'd1);
    chk("wr3_din",      8'(rf_din),   8'hA);
    tick();

    // B reads entry 3 the cycle after the write
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd3;
    #1;
    chk("rd3_b_gnt",    8'(b_gnt),    8'd1);
    chk("wr3_a_rvalid", 8'(a_rvalid), 8'd0);
    chk("wr3_rdata",    8'(rdata),    8'h5);
    tick();
    b_req = 1'b0;
    #1;
    chk("rd3_b_rvalid", 8'(b_rvalid), 8'd1);
    chk("rd3_a_rvalid", 8'(a_rvalid), 8'd0);
    chk("rd3_rdata",    8'(rdata),    8'hA);
    tick();

    // Both hold reads for 4 cycles: A (entry 1 = 5) and B (entry 3 = A) alternate
    a_req = 1'b1; a_addr = 3'd1;
    b_req = 1'b1; b_addr = 3'd3;
    #1;
    chk("rr0_a_gnt", 8'(a_gnt), 8'd1);
    chk("rr0_b_gnt", 8'(b_gnt), 8'd0);
    chk("rr0_a_rv",  8'(a_rvalid), 8'd0);
    chk("rr0_b_rv",  8'(b_rvalid), 8'd0);
    tick();
    #1;
    chk("rr1_b_gnt", 8'(b_gnt), 8'd1);
    chk("rr1_a_gnt", 8'(a_gnt), 8'd0);
    chk("rr1_a_rv",  8'(a_rvalid), 8'd1);
    chk("rr1_rdata", 8'(rdata), 8'h5);
    tick();
    #1;
    chk("rr2_a_gnt", 8'(a_gnt), 8'd1);
    chk("rr2_b_rv",  8'(b_rvalid), 8'd1);
    chk("rr2_a_rv",  8'(a_rvalid), 8'd0);
    chk("rr2_rdata", 8'(rdata), 8'hA);
    tick();
    #1;
    chk("rr3_b_gnt", 8'(b_gnt), 8'd1);
    chk("rr3_a_rv",  8'(a_rvalid), 8'd1);
    chk("rr3_rdata", 8'(rdata), 8'h5);
    tick();
    a_req = 1'b0; b_req = 1'b0;
    #1;
    chk("rr4_b_rv",  8'(b_rvalid), 8'd1);
    chk("rr4_rdata", 8'(rdata), 8'hA);
    chk("rr4_gnts",  8'({a_gnt, b_gnt}), 8'd0);
    tick();

    // Flush with both requesters pending
    a_req = 1'b1; a_addr = 3'd2;
    b_req = 1'b1; b_addr = 3'd3;
    flush = 1'b1;
    #1;
    chk("fl_clr",  8'(rf_clr), 8'd1);
    chk("fl_busy", 8'(busy), 8'd1);
    chk("fl_gnts", 8'({a_gnt, b_gnt}), 8'd0);
    chk("fl_load", 8'(rf_load), 8'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("pfl_a_gnt", 8'(a_gnt), 8'd1);
    chk("pfl_busy",  8'(busy), 8'd0);
    chk("pfl_clr",   8'(rf_clr), 8'd0);
    tick();
    a_req = 1'b0;
    #1;
    chk("pfl_a_rv",    8'(a_rvalid), 8'd1);
    chk("pfl_rdata2",  8'(rdata), 8'h0);
    chk("pfl_b_gnt",   8'(b_gnt), 8'd1);
    tick();
    b_req = 1'b0;
    #1;
    chk("pfl_b_rv",    8'(b_rvalid), 8'd1);
    chk("pfl_rdata3",  8'(rdata), 8'h0);
    tick();

    // Reset mid-sweep restarts the sweep from entry 0
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("ms_addr4", 8'(rf_addr), 8'd4);
    clr_n = 1'b0;
    #1;
    chk("ms_rst_busy", 8'(busy), 8'd0);
    chk("ms_rst_load", 8'(rf_load), 8'd0);
    chk("ms_rst_addr", 8'(rf_addr), 8'd0);
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ms_sweep_addr", 8'(rf_addr), 8'(i));
      chk("ms_sweep_busy", 8'(busy), 8'd1);
      tick();
    end
    #1;
    chk("ms_done_busy", 8'(busy), 8'd0);

    // No-sweep instance: request in the first cycle out of reset is granted at once
    chk("ns_rst_busy", 8'(busy2), 8'd0);
    chk("ns_rst_gnt",  8'(a2_gnt), 8'd0);
    clr2_n = 1'b1;
    a2_req = 1'b1; a2_we = 1'b0; a2_addr = 3'd6;
    #1;
    chk("ns_a_gnt", 8'(a2_gnt), 8'd1);
    chk("ns_busy0", 8'(busy2), 8'd0);
    chk("ns_addr",  8'(rf_addr2), 8'd6);
    chk("ns_load0", 8'(rf_load2), 8'd0);
    tick();
    a2_req = 1'b0;
    b2_req = 1'b1; b2_we = 1'b1; b2_addr = 3'd1; b2_wdata = 4'h3;
    #1;
    chk("ns_b_gnt",  8'(b2_gnt), 8'd1);
    chk("ns_din",    8'(rf_din2), 8'h3);
    chk("ns_load1",  8'(rf_load2), 8'd1);
    chk("ns_clr",    8'(rf_clr2), 8'd0);
    chk("ns_a_rv",   8'(a2_rvalid), 8'd1);
    chk("ns_rdata",  8'(rdata2), 8'h0);
    chk("ns_busy1",  8'(busy2), 8'd0);
    tick();
    b2_req = 1'b0; b2_we = 1'b0;
    #1;
    chk("ns_b_rv",   8'(b2_rvalid), 8'd0);
    chk("ns_busy2",  8'(busy2), 8'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Controller that shares the 8-entry x 4-bit register file between two requesters, A and B, using round-robin arbitration. After reset it runs an initialisation sweep that writes INIT_VAL into every entry. It also provides a one-cycle global flush. It drives the register file's din/addr/load/clr ports and registers the file's combinational read output.

Parameters:
DATA_W, 4, data width of each entry
ADDR_W, 3, address width (NUM_REGS = 2**ADDR_W = 8)
INIT_VAL, 0, value written to every entry during the post-reset sweep
SWEEP_EN, 1, 1 = run the sweep after reset; 0 = enter RUN directly

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  reset, asynchronous, active-low
a_req  in  1  requester A wants a transfer; held until a_gnt
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  ADDR_W  A target entry
a_wdata  in  DATA_W  A write data
a_gnt  out  1  A transfer accepted this cycle (combinational)
a_rvalid  out  1  A read data valid on rdata (1-cycle pulse)
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  as for A
rdata  out  DATA_W  registered read data, shared by A and B
flush  in  1  request to clear all entries
busy  out  1  sweep or flush in progress this cycle
rf_din  out  DATA_W  to register file din
rf_addr  out  ADDR_W  to register file addr
rf_load  out  1  to register file load
rf_clr  out  1  to register file clr (clears all entries at the edge)
rf_q  in  DATA_W  from register file q (combinational read of rf_addr)

Behaviour:
- Reset (clr_n=0, async):
  - state = SWEEP (RUN if SWEEP_EN=0); sweep_cnt = 0; last_gnt = B, so A wins the first tie.
  - rdata = 0; a_rvalid = b_rvalid = 0.
- Combinational outputs default to 0 when not driven: gnts, rf_load, rf_clr, rf_addr, rf_din.
- SWEEP state:
  - Each cycle: rf_addr = sweep_cnt, rf_din = INIT_VAL, rf_load = 1, busy = 1, no grants.
  - sweep_cnt increments; after cnt = 7 the next state is RUN. The sweep lasts exactly 8 cycles.
  - flush is ignored during SWEEP.
  - Reset asserted mid-sweep restarts the sweep at 0.
- RUN state, priority order within a cycle:
  - flush=1: rf_clr = 1, busy = 1, no grants, last_gnt unchanged. Pending requests stall and keep req asserted.
  - Otherwise arbitrate:
    - Only one req: grant it.
    - Both req: grant the requester not in last_gnt.
    - last_gnt updates only on a grant.
  - The granted requester drives rf_addr = x_addr, rf_din = x_wdata, rf_load = x_we.
  - A grant completes the transfer in that cycle; the requester may drop req or present a new request next cycle.
- Read latency:
  - On a granted read, rdata <= rf_q at the edge; x_rvalid = 1 for exactly the following cycle.
  - rdata holds its value until the next granted read; writes do not alter rdata.
- Write/read ordering: a write granted in cycle N is visible to a read granted in cycle N+1.
- Back-to-back granted reads give consecutive rvalid pulses, attributed to the requester granted in the prior cycle.
- Both requests addressing the same entry: no special handling; they are serialised by the arbiter.
- No state after RUN: the controller stays in RUN until reset.

Decomposition:
- Package regfile_pkg: DATA_W, ADDR_W, NUM_REGS constants; state enum {SWEEP, RUN}; requester id enum {REQ_A, REQ_B}.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], en, clk, clr_n.
  - Output: gnt[1:0], one-hot or zero.
  - Owns the last_gnt register, updated on any grant.

Test Plan:
- INIT_VAL=4'h5: release reset → busy=1 and rf_load=1 for 8 cycles with rf_addr 0..7; busy drops; A reads addr 7 → a_rvalid next cycle with rdata=4'h5.
- A writes addr 3 = 4'hA (a_gnt same cycle); next cycle B reads addr 3 → b_gnt, then b_rvalid with rdata=4'hA; a_rvalid stays 0.
- A and B both hold reads for 4 cycles → grant sequence A,B,A,B; rvalid pulses alternate a,b,a,b, each one cycle after its grant.
- flush with both requesters active → one cycle of rf_clr=1, busy=1, no gnt; next cycle A is granted; A reads addr 2 → rdata=4'h0.
- clr_n asserted when sweep_cnt=4 → outputs zero immediately; on release the sweep restarts at rf_addr=0 and lasts 8 full cycles.
- SWEEP_EN=0 → a_req asserted in the first cycle after reset gets a_gnt in that cycle; busy never asserts.
